// File: rtl/data_mem_responder.sv
// Data-memory responder: word-addressed RAM with programmable read latency and a one-cycle ready pulse.
// Optional read/write access counters are enabled by defining DMEM_PERF_CNT_EN.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS  = 1024,
   parameter int unsigned READ_LATENCY = 1,
   parameter logic [31:0] ADDR_BASE    = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RES,
   input  logic        memRead,
   input  logic        memWrite,
   input  logic [31:0] memAddr,
   input  logic [31:0] memDataIn,
   output logic [31:0] memDataOut,
   output logic        memReady,
   output logic        errFlag,
   input  logic        errClear
`ifdef DMEM_PERF_CNT_EN
   ,
   output logic [31:0] rdCount,
   output logic [31:0] wrCount
`endif
);

   // state     | meaning
   // IDLE      | sampling strobes, accepts one access per edge
   // READ_WAIT | read accepted, counting down remaining latency
   // RESP      | memReady high for this cycle, then back to IDLE
   typedef enum logic [1:0] {IDLE, READ_WAIT, RESP} stateT;

   localparam int unsigned AW   = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

   stateT         state;
   logic [31:0]   ram [DEPTH_WORDS];
   logic [31:0]   offset;
   logic [AW-1:0] idx;
   logic [AW-1:0] rdIdx;
   logic          rdBad;
   logic [2:0]    cnt;
   logic          addrOk;
   logic          accRd;
   logic          accWr;
   logic          accErr;
   logic          wrEn;

   always_comb begin
      offset = memAddr - ADDR_BASE;
      idx    = offset[AW+1:2];
      // ADDR_BASE is aligned, so the low offset bits equal the low address bits
      addrOk = (offset[1:0] == 2'b00) && (memAddr >= ADDR_BASE) && ({1'b0, offset} < SPAN);
      accWr  = (state == IDLE) && memWrite;
      accRd  = (state == IDLE) && memRead && !memWrite;
      accErr = (accWr || accRd) && (!addrOk || (memRead && memWrite));
      wrEn   = accWr && addrOk;
   end

   always_ff @(posedge CLK) begin
      if (wrEn) ram[idx] <= memDataIn;
   end

   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         state      <= IDLE;
         memDataOut <= '0;
         memReady   <= 1'b0;
         errFlag    <= 1'b0;
         cnt        <= '0;
         rdIdx      <= '0;
         rdBad      <= 1'b0;
      end else begin
         memReady <= 1'b0;
         if (accErr)        errFlag <= 1'b1;
         else if (errClear) errFlag <= 1'b0;
         case (state)
            IDLE: begin
               if (accWr) begin
                  state    <= RESP;
                  memReady <= 1'b1;
               end else if (accRd) begin
                  rdIdx <= idx;
                  rdBad <= !addrOk;
                  cnt   <= 3'(READ_LATENCY - 1);
                  if (READ_LATENCY == 1) begin
                     memDataOut <= addrOk ? ram[idx] : '0;
                     state      <= RESP;
                     memReady   <= 1'b1;
                  end else begin
                     state <= READ_WAIT;
                  end
               end
            end
            READ_WAIT: begin
               cnt <= cnt - 3'd1;
               if (cnt == 3'd1) begin
                  memDataOut <= rdBad ? '0 : ram[rdIdx];
                  state      <= RESP;
                  memReady   <= 1'b1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DMEM_PERF_CNT_EN
   // The both-strobes case is excluded from accRd, so it counts as a write only
   always_ff @(posedge CLK or negedge RES) begin
      if (!RES) begin
         rdCount <= '0;
         wrCount <= '0;
      end else begin
         if (accRd) rdCount <= rdCount + 32'd1;
         if (accWr) wrCount <= wrCount + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (read latency 1, 3, 4) share one stimulus stream
// and are compared against an array-based reference model of the memory, read data and error flag.
module tb_data_mem_responder;
   localparam int          DEPTH = 64;
   localparam logic [31:0] BASE  = 32'h0000_0400;

   logic        CLK = 1'b0;
   logic        RES = 1'b1;
   logic        memRead = 1'b0;
   logic        memWrite = 1'b0;
   logic        errClear = 1'b0;
   logic [31:0] memAddr = '0;
   logic [31:0] memDataIn = '0;
   logic [31:0] dOut [3];
   logic        rdy [3];
   logic        errF [3];
`ifdef DMEM_PERF_CNT_EN
   logic [31:0] rdCnt [3];
   logic [31:0] wrCnt [3];
`endif

   always #5 CLK = ~CLK;

   for (genvar g = 0; g < 3; g++) begin : gDut
      data_mem_responder #(
         .DEPTH_WORDS (DEPTH),
         .READ_LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4)),
         .ADDR_BASE   (BASE)
      ) dut (
         .CLK       (CLK),
         .RES       (RES),
         .memRead   (memRead),
         .memWrite  (memWrite),
         .memAddr   (memAddr),
         .memDataIn (memDataIn),
         .memDataOut(dOut[g]),
         .memReady  (rdy[g]),
         .errFlag   (errF[g]),
         .errClear  (errClear)
`ifdef DMEM_PERF_CNT_EN
         ,
         .rdCount   (rdCnt[g]),
         .wrCount   (wrCnt[g])
`endif
      );
   end

   int          errors = 0;
   int          checks = 0;
   int          lat [3];
   logic [31:0] refMem [DEPTH];
   logic [31:0] refOut = '0;
   logic        refErr = 1'b0;
   int unsigned refRd = 0;
   int unsigned refWr = 0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit addrGood(input logic [31:0] a);
      return (a[1:0] == 2'b00) && (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
   endfunction

   // Reference: what an access does to memory, read data, error flag and counters
   task automatic modelAccess(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic clr);
      bit good;
      good = addrGood(a);
      if (wr) begin
         refWr++;
         if (good) refMem[(a - BASE) / 4] = d;
      end else if (rd) begin
         refRd++;
         refOut = good ? refMem[(a - BASE) / 4] : 32'h0;
      end
      if ((rd || wr) && (!good || (rd && wr))) refErr = 1'b1;
      else if (clr)                            refErr = 1'b0;
   endtask

   task automatic xact(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic clr, input logic hold);
      int readyCyc [3];
      @(negedge CLK);
      memRead = rd; memWrite = wr; memAddr = a; memDataIn = d; errClear = clr;
      @(posedge CLK);
      modelAccess(rd, wr, a, d, clr);
      for (int i = 0; i < 3; i++) readyCyc[i] = wr ? 1 : (rd ? lat[i] : 0);
      for (int k = 1; k <= 6; k++) begin
         @(negedge CLK);
         for (int i = 0; i < 3; i++) begin
            checkVal($sformatf("ready_L%0d_c%0d_a%h", lat[i], k, a), 32'(rdy[i]),
                     32'(k == readyCyc[i]));
            if (k == 1) checkVal($sformatf("err_L%0d_a%h", lat[i], a), 32'(errF[i]), 32'(refErr));
            if (k == readyCyc[i])
               checkVal($sformatf("dout_L%0d_a%h", lat[i], a), dOut[i], refOut);
         end
         if (k == 1) errClear = 1'b0;
         if ((k == 1 && !hold) || k == 2) begin
            memRead = 1'b0; memWrite = 1'b0;
         end
      end
   endtask

   initial begin
      lat[0] = 1; lat[1] = 3; lat[2] = 4;
      #1 RES = 1'b0;
      repeat (2) @(negedge CLK);
      for (int i = 0; i < 3; i++) begin
         checkVal($sformatf("rst_ready_%0d", i), 32'(rdy[i]), 32'h0);
         checkVal($sformatf("rst_dout_%0d", i), dOut[i], 32'h0);
         checkVal($sformatf("rst_err_%0d", i), 32'(errF[i]), 32'h0);
      end
      RES = 1'b1;

      for (int w = 0; w < DEPTH; w++) xact(1'b0, 1'b1, BASE + 32'(4 * w), $urandom, 1'b0, 1'b0);

      xact(1'b0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0);
      xact(1'b1, 1'b0, BASE + 32'h10, 32'h0, 1'b0, 1'b1);
      xact(1'b1, 1'b0, BASE + 32'h13, 32'h0, 1'b0, 1'b0);
      xact(1'b0, 1'b1, BASE + 32'(4 * DEPTH), 32'hFFFF_0000, 1'b0, 1'b0);
      xact(1'b0, 1'b1, BASE - 32'h4, 32'h0BAD_0BAD, 1'b0, 1'b0);
      xact(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      xact(1'b1, 1'b0, BASE + 32'(4 * DEPTH - 4), 32'h0, 1'b0, 1'b0);
      xact(1'b1, 1'b1, BASE + 32'h20, 32'h1234_5678, 1'b0, 1'b0);
      xact(1'b1, 1'b0, BASE + 32'h20, 32'h0, 1'b1, 1'b0);
      xact(1'b1, 1'b0, BASE + 32'h11, 32'h0, 1'b1, 1'b0);
      xact(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

      // Reset two cycles after a read is accepted aborts it in the slower instances
      @(negedge CLK);
      memRead = 1'b1; memAddr = BASE + 32'h10;
      @(posedge CLK);
      modelAccess(1'b1, 1'b0, BASE + 32'h10, 32'h0, 1'b0);
      @(negedge CLK);
      checkVal("abort_ready_L1", 32'(rdy[0]), 32'h1);
      checkVal("abort_dout_L1", dOut[0], 32'hDEAD_BEEF);
      memRead = 1'b0;
      @(negedge CLK);
      RES = 1'b0;
      refOut = '0; refErr = 1'b0; refRd = 0; refWr = 0;
      for (int c = 0; c < 4; c++) begin
         #1;
         for (int i = 0; i < 3; i++) begin
            checkVal($sformatf("abort_ready_L%0d_c%0d", lat[i], c), 32'(rdy[i]), 32'h0);
            checkVal($sformatf("abort_dout_L%0d_c%0d", lat[i], c), dOut[i], 32'h0);
         end
         @(negedge CLK);
         if (c == 2) RES = 1'b1;
      end
      xact(1'b1, 1'b0, BASE + 32'h10, 32'h0, 1'b0, 1'b0);

      for (int n = 0; n < 60; n++) begin
         int          op;
         int          kind;
         logic [31:0] a;
         op   = $urandom_range(0, 9);
         kind = $urandom_range(0, 9);
         if (kind <= 6)      a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
         else if (kind == 7) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
         else if (kind == 8) a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15));
         else                a = BASE - 32'(4 * $urandom_range(1, 16));
         xact(op >= 4, op <= 3 || op == 9, a, $urandom, $urandom_range(0, 3) == 0,
              1'($urandom_range(0, 1)));
      end

`ifdef DMEM_PERF_CNT_EN
      for (int i = 0; i < 3; i++) begin
         checkVal($sformatf("wrCount_L%0d", lat[i]), wrCnt[i], refWr);
         checkVal($sformatf("rdCount_L%0d", lat[i]), rdCnt[i], refRd);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
